key_irq_servicer: RTL

//  Avalon-MM master that owns the 2-bit key PIO slave: programs its irq_mask, services its irq,

---
 rtl/key_irq_servicer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/key_irq_servicer.sv
// rtl/key_irq_servicer.sv - Avalon-MM master servicing a 2-bit key PIO irq into a valid/ready event stream
//
// Purpose: programs the key PIO irq_mask, services its irq by reading then
// clearing edge_capture, and hands each masked edge set to fabric logic over a
// valid/ready stream. A holdoff counter after each delivered event masks
// contact-bounce re-triggers.
//
// Ports:
//   clk_i, reset_i        single clock, synchronous active-high reset
//   pio_address_o         PIO register select (0 data, 2 irq_mask, 3 edge_capture)
//   pio_chipselect_o      PIO chipselect
//   pio_write_n_o         PIO write strobe, active-low
//   pio_writedata_o       PIO write data
//   pio_readdata_i        PIO read data, registered in the PIO (1 cycle after address)
//   pio_irq_i             PIO level interrupt
//   cfg_mask_i            new irq_mask value
//   cfg_mask_wr_i         1-cycle pulse: load cfg_mask_i and reprogram the PIO
//   evt_valid_o/evt_ready_i/evt_data_o  key event stream (data already masked)
//   evt_level_o           key levels snapshot (only with KEY_LEVEL_SNAPSHOT_EN)
//   spurious_cnt_o        services that found no masked edge, saturating
//   busy_o                high in every state except IDLE
//
// Optional feature: define KEY_LEVEL_SNAPSHOT_EN to read the PIO data register
// after a non-empty capture and present the key levels alongside the event.

module key_irq_servicer #(
   parameter int                DATA_W    = 2,
   parameter logic [DATA_W-1:0] INIT_MASK = {DATA_W{1'b1}},
   parameter int                HOLDOFF   = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   output logic [1:0]        pio_address_o,
   output logic              pio_chipselect_o,
   output logic              pio_write_n_o,
   output logic [DATA_W-1:0] pio_writedata_o,
   input  logic [DATA_W-1:0] pio_readdata_i,
   input  logic              pio_irq_i,
   input  logic [DATA_W-1:0] cfg_mask_i,
   input  logic              cfg_mask_wr_i,
   output logic              evt_valid_o,
   input  logic              evt_ready_i,
   output logic [DATA_W-1:0] evt_data_o,
`ifdef KEY_LEVEL_SNAPSHOT_EN
   output logic [DATA_W-1:0] evt_level_o,
`endif
   output logic [7:0]        spurious_cnt_o,
   output logic              busy_o
);

   localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_RD    = 3'd2,
      S_WAIT  = 3'd3,
      S_CLR   = 3'd4,
      S_PUSH  = 3'd5,
      S_LRD   = 3'd6,
      S_LWAIT = 3'd7
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] mask_q, mask_d;
   logic [DATA_W-1:0] cap_q, cap_d;
   logic [HO_W-1:0]   holdoff_q, holdoff_d;
   logic [7:0]        spur_q, spur_d;
   logic              pend_q, pend_d;
`ifdef KEY_LEVEL_SNAPSHOT_EN
   logic [DATA_W-1:0] lvl_q, lvl_d;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= S_INIT;
         mask_q    <= INIT_MASK;
         cap_q     <= '0;
         holdoff_q <= '0;
         spur_q    <= '0;
         pend_q    <= 1'b0;
`ifdef KEY_LEVEL_SNAPSHOT_EN
         lvl_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         cap_q     <= cap_d;
         holdoff_q <= holdoff_d;
         spur_q    <= spur_d;
         pend_q    <= pend_d;
`ifdef KEY_LEVEL_SNAPSHOT_EN
         lvl_q     <= lvl_d;
`endif
      end
   end

   always_comb begin
      state_d          = state_q;
      mask_d           = mask_q;
      cap_d            = cap_q;
      spur_d           = spur_q;
      pend_d           = pend_q;
`ifdef KEY_LEVEL_SNAPSHOT_EN
      lvl_d            = lvl_q;
`endif
      // Holdoff counts down in every state; a handshake in PUSH reloads it below.
      holdoff_d        = (holdoff_q != '0) ? holdoff_q - HO_W'(1) : holdoff_q;
      pio_chipselect_o = 1'b0;
      pio_write_n_o    = 1'b1;
      pio_address_o    = 2'd0;
      pio_writedata_o  = '0;
      evt_valid_o      = 1'b0;

      case (state_q)
         S_INIT: begin
            pio_chipselect_o = 1'b1;
            pio_write_n_o    = 1'b0;
            pio_address_o    = 2'd2;
            pio_writedata_o  = mask_q;
            state_d          = S_IDLE;
         end
         S_IDLE: begin
            if (pend_q) begin
               pend_d  = 1'b0;
               state_d = S_INIT;
            end else if (pio_irq_i && holdoff_q == '0) begin
               state_d = S_RD;
            end
         end
         S_RD: begin
            pio_chipselect_o = 1'b1;
            pio_address_o    = 2'd3;
            state_d          = S_WAIT;
         end
         S_WAIT: begin
            // PIO readdata is registered: the edge_capture value is valid now.
            pio_address_o = 2'd3;
            cap_d         = pio_readdata_i & mask_q;
            state_d       = S_CLR;
         end
         S_CLR: begin
            // Any write to edge_capture clears every bit.
            pio_chipselect_o = 1'b1;
            pio_write_n_o    = 1'b0;
            pio_address_o    = 2'd3;
            pio_writedata_o  = '1;
            if (cap_q != '0) begin
`ifdef KEY_LEVEL_SNAPSHOT_EN
               state_d = S_LRD;
`else
               state_d = S_PUSH;
`endif
            end else begin
               state_d = S_IDLE;
               if (spur_q != 8'hFF) spur_d = spur_q + 8'd1;
            end
         end
`ifdef KEY_LEVEL_SNAPSHOT_EN
         S_LRD: begin
            pio_chipselect_o = 1'b1;
            pio_address_o    = 2'd0;
            state_d          = S_LWAIT;
         end
         S_LWAIT: begin
            lvl_d   = pio_readdata_i;
            state_d = S_PUSH;
         end
`endif
         S_PUSH: begin
            evt_valid_o = 1'b1;
            if (evt_ready_i) begin
               holdoff_d = HO_W'(HOLDOFF);
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_INIT;
      endcase

      // A mask update from IDLE reprograms at once; elsewhere it is deferred
      // and the latest value is written by a single INIT.
      if (cfg_mask_wr_i) begin
         mask_d = cfg_mask_i;
         if (state_q == S_IDLE) state_d = S_INIT;
         else                   pend_d  = 1'b1;
      end

      // Keep the bus and stream quiet while reset is held so the PIO only sees
      // the INIT write once reset releases.
      if (reset_i) begin
         pio_chipselect_o = 1'b0;
         pio_write_n_o    = 1'b1;
         pio_address_o    = 2'd0;
         pio_writedata_o  = '0;
         evt_valid_o      = 1'b0;
      end
   end

   assign evt_data_o     = cap_q;
   assign spurious_cnt_o = spur_q;
   assign busy_o         = (state_q != S_IDLE);
`ifdef KEY_LEVEL_SNAPSHOT_EN
   assign evt_level_o    = lvl_q;
`endif

endmodule
